alu_core: RTL and testbench
===========================

ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled only on rising clk.
REQ-004 alu_src0  input  32  operand A.
REQ-005 alu_src1  input  32  operand B; bits [4:0] give the shift/rotate amount.
REQ-006 alu_op  input  5  operation select, full 0..31 decode.
REQ-007 alu_res  output  32  registered result.

Function
REQ-008 alu_res SHALL register f(alu_op, alu_src0, alu_src1) sampled at each rising clk; latency is 1 cycle, with no handshake and no stall.
REQ-009 Arithmetic SHALL be modulo 2^32, with no overflow or carry flags; "s" means two's-complement signed and "u" means unsigned.
REQ-010 Opcodes 0-7: 0 ADD a+b; 1 SUB a-b; 2 SLL a<<b[4:0]; 3 SLT {31'b0, a<b (s)}; 4 SLTU {31'b0, a<b (u)}; 5 XOR; 6 SRL logical right shift; 7 SRA arithmetic right shift.
REQ-011 Opcodes 8-15: 8 OR; 9 AND; 10 PASS b; 11 PASS a; 12 MUL low 32 bits of a*b; 13 MULH high 32 bits (s*s); 14 MULHSU high 32 bits (a signed, b unsigned); 15 MULHU high 32 bits (u*u).
REQ-012 Opcodes 16-23: 16 EQ {31'b0, a==b}; 17 NE; 18 GE (s); 19 GEU (u); 20 MIN (s); 21 MAX (s); 22 MINU; 23 MAXU.
REQ-013 Opcodes 24-31: 24 ANDN a&~b; 25 ORN a|~b; 26 XNOR ~(a^b); 27 CLZ(a); 28 CTZ(a); 29 CPOP(a); 30 ROL a by b[4:0]; 31 ROR a by b[4:0].
REQ-014 CLZ and CTZ of 0 SHALL return 32; CPOP SHALL return 0..32; shift/rotate amount 0 SHALL return a unchanged.
REQ-015 Only b[4:0] SHALL affect shifts and rotates; b[31:5] SHALL be ignored for those ops.
REQ-016 Comparison ops SHALL return exactly 32'h0 or 32'h1.
REQ-017 Operand or opcode changes between edges SHALL not affect alu_res until the next rising clk.
REQ-018 The result datapath SHALL be combinational ahead of the single output register, with no multicycle paths.

Reset
REQ-019 When rst_n=0 at a rising clk, alu_res SHALL become 32'h0 and inputs are ignored that cycle.
REQ-020 Reset asserted mid-stream SHALL override any pending result.
REQ-021 On the first rising clk with rst_n=1, alu_res SHALL hold the computed result.
REQ-022 Before the first reset, alu_res is undefined.

Verification
REQ-023 Reset: rst_n=0 for 2 cycles with any inputs -> alu_res=0; release -> alu_res updates one cycle later.
REQ-024 Opcode sweep with a=FFFFFFFF, b=2, one op per cycle starting at op 0, checking each result one cycle later:
- ADD 00000001; SUB FFFFFFFD; SLL FFFFFFFC; SLT 1; SLTU 0; XOR FFFFFFFD; SRL 3FFFFFFF; SRA FFFFFFFF
- MUL FFFFFFFE; MULH FFFFFFFF; MULHSU FFFFFFFF; MULHU 00000001
- MIN FFFFFFFF; MAXU FFFFFFFF; CLZ 0; CTZ 0; CPOP 20; ROR FFFFFFFF
REQ-025 Opcode wrap: increment op from 31 -> op 0 (ADD) decoded correctly, result 00000001.
REQ-026 Boundaries:
- a=80000000, b=1: SUB 7FFFFFFF; SLT 1; SLTU 0; SRA C0000000.
- a=0: CLZ 20; CTZ 20.
- b=FFFFFFE0: SLL result equals a (amount 0).
REQ-027 Latency: change inputs every cycle -> each alu_res equals the function of the inputs sampled one edge earlier; no combinational input-to-output path.

Source files
------------

// File: rtl/alu_core_if.sv
// alu_core_if: operand/opcode/result bundle for alu_core.
//   alu_src0 [31:0]  operand A              (master -> slave)
//   alu_src1 [31:0]  operand B, [4:0] shamt (master -> slave)
//   alu_op   [4:0]   operation select       (master -> slave)
//   alu_res  [31:0]  registered result      (slave -> master)
interface alu_core_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 5;

  logic [XLEN-1:0] alu_src0;
  logic [XLEN-1:0] alu_src1;
  logic [OPW-1:0]  alu_op;
  logic [XLEN-1:0] alu_res;

  modport master (
    output alu_src0,
    output alu_src1,
    output alu_op,
    input  alu_res
  );

  modport slave (
    input  alu_src0,
    input  alu_src1,
    input  alu_op,
    output alu_res
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: 32-bit single-cycle ALU with one output register.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears alu_res
//   bus    alu_core_if.slave: alu_src0/alu_src1/alu_op in, alu_res out
module alu_core (
  input  logic       clk,
  input  logic       rst_n,
  alu_core_if.slave  bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;
  localparam int unsigned CNTW = 6;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,  OP_SUB    = 5'd1,  OP_SLL    = 5'd2,  OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,  OP_XOR    = 5'd5,  OP_SRL    = 5'd6,  OP_SRA    = 5'd7,
    OP_OR     = 5'd8,  OP_AND    = 5'd9,  OP_PASSB  = 5'd10, OP_PASSA  = 5'd11,
    OP_MUL    = 5'd12, OP_MULH   = 5'd13, OP_MULHSU = 5'd14, OP_MULHU  = 5'd15,
    OP_EQ     = 5'd16, OP_NE     = 5'd17, OP_GE     = 5'd18, OP_GEU    = 5'd19,
    OP_MIN    = 5'd20, OP_MAX    = 5'd21, OP_MINU   = 5'd22, OP_MAXU   = 5'd23,
    OP_ANDN   = 5'd24, OP_ORN    = 5'd25, OP_XNOR   = 5'd26, OP_CLZ    = 5'd27,
    OP_CTZ    = 5'd28, OP_CPOP   = 5'd29, OP_ROL    = 5'd30, OP_ROR    = 5'd31
  } op_e;

  // Leading zeros; an all-zero word yields XLEN.
  function automatic logic [CNTW-1:0] clz32(input logic [XLEN-1:0] v);
    logic found;
    clz32 = '0;
    found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (v[i]) found = 1'b1;
      else if (!found) clz32 = clz32 + CNTW'(1);
    end
  endfunction

  // Trailing zeros; an all-zero word yields XLEN.
  function automatic logic [CNTW-1:0] ctz32(input logic [XLEN-1:0] v);
    logic found;
    ctz32 = '0;
    found = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (v[i]) found = 1'b1;
      else if (!found) ctz32 = ctz32 + CNTW'(1);
    end
  endfunction

  function automatic logic [CNTW-1:0] cpop32(input logic [XLEN-1:0] v);
    cpop32 = '0;
    for (int i = 0; i < XLEN; i++) cpop32 = cpop32 + CNTW'(v[i]);
  endfunction

  logic [XLEN-1:0]   a, b;
  logic [SHW-1:0]    sh;
  logic              lt_s, lt_u, eq;
  logic signed [2*XLEN-1:0] prod_ss;
  logic [XLEN-1:0]   mulh_ss, mulh_su, mulh_uu;
  logic [XLEN-1:0]   res_c;

  assign a  = bus.alu_src0;
  assign b  = bus.alu_src1;
  assign sh = b[SHW-1:0];

  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;
  assign eq   = a == b;

  // One signed 64-bit product; the unsigned-operand high halves are derived
  // by adding back the operand that a set sign bit subtracted (mod 2^32).
  assign prod_ss = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
  assign mulh_ss = prod_ss[2*XLEN-1:XLEN];
  assign mulh_su = mulh_ss + (b[XLEN-1] ? a : '0);
  assign mulh_uu = mulh_su + (a[XLEN-1] ? b : '0);

  // Result select, combinational ahead of the output register.
  always_comb begin
    res_c = '0;
    case (op_e'(bus.alu_op))
      OP_ADD:    res_c = a + b;
      OP_SUB:    res_c = a - b;
      OP_SLL:    res_c = a << sh;
      OP_SLT:    res_c = XLEN'(lt_s);
      OP_SLTU:   res_c = XLEN'(lt_u);
      OP_XOR:    res_c = a ^ b;
      OP_SRL:    res_c = a >> sh;
      OP_SRA:    res_c = XLEN'($signed(a) >>> sh);
      OP_OR:     res_c = a | b;
      OP_AND:    res_c = a & b;
      OP_PASSB:  res_c = b;
      OP_PASSA:  res_c = a;
      OP_MUL:    res_c = prod_ss[XLEN-1:0];
      OP_MULH:   res_c = mulh_ss;
      OP_MULHSU: res_c = mulh_su;
      OP_MULHU:  res_c = mulh_uu;
      OP_EQ:     res_c = XLEN'(eq);
      OP_NE:     res_c = XLEN'(!eq);
      OP_GE:     res_c = XLEN'(!lt_s);
      OP_GEU:    res_c = XLEN'(!lt_u);
      OP_MIN:    res_c = lt_s ? a : b;
      OP_MAX:    res_c = lt_s ? b : a;
      OP_MINU:   res_c = lt_u ? a : b;
      OP_MAXU:   res_c = lt_u ? b : a;
      OP_ANDN:   res_c = a & ~b;
      OP_ORN:    res_c = a | ~b;
      OP_XNOR:   res_c = ~(a ^ b);
      OP_CLZ:    res_c = XLEN'(clz32(a));
      OP_CTZ:    res_c = XLEN'(ctz32(a));
      OP_CPOP:   res_c = XLEN'(cpop32(a));
      // Rotates via the doubled word so amount 0 needs no special case.
      OP_ROL:    res_c = XLEN'(({a, a} << sh) >> XLEN);
      OP_ROR:    res_c = XLEN'({a, a} >> sh);
    endcase
  end

  // Output register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) bus.alu_res <= '0;
    else        bus.alu_res <= res_c;
  end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: randomized scoreboard bench for alu_core against a
// behavioural model written with plain integer arithmetic.
module tb_alu_core;

  logic clk;
  logic rst_n;
  alu_core_if bus ();

  alu_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] exp;
    bit [4:0]  op;
    int        id;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_iss = 0;

  // Reference model from the operation definitions.
  function automatic bit [31:0] model(bit [4:0] op, bit [31:0] a, bit [31:0] b);
    int          sa, sb, n;
    int unsigned sh;
    longint      pss, psu;
    bit [63:0]   puu;
    bit [31:0]   r;
    sa  = a;
    sb  = b;
    sh  = {27'b0, b[4:0]};
    pss = longint'(sa) * longint'(sb);
    psu = longint'(sa) * longint'({32'b0, b});
    puu = {32'b0, a} * {32'b0, b};
    n   = 0;
    r   = 32'h0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << sh;
      5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  r = (a < b) ? 32'd1 : 32'd0;
      5'd5:  r = a ^ b;
      5'd6:  r = a >> sh;
      5'd7:  r = 32'(sa >>> sh);
      5'd8:  r = a | b;
      5'd9:  r = a & b;
      5'd10: r = b;
      5'd11: r = a;
      5'd12: r = puu[31:0];
      5'd13: r = pss[63:32];
      5'd14: r = psu[63:32];
      5'd15: r = puu[63:32];
      5'd16: r = (a == b) ? 32'd1 : 32'd0;
      5'd17: r = (a != b) ? 32'd1 : 32'd0;
      5'd18: r = (sa >= sb) ? 32'd1 : 32'd0;
      5'd19: r = (a >= b) ? 32'd1 : 32'd0;
      5'd20: r = (sa < sb) ? a : b;
      5'd21: r = (sa > sb) ? a : b;
      5'd22: r = (a < b) ? a : b;
      5'd23: r = (a > b) ? a : b;
      5'd24: r = a & ~b;
      5'd25: r = a | ~b;
      5'd26: r = ~(a ^ b);
      5'd27: begin
        while (n < 32 && a[31-n] == 1'b0) n++;
        r = 32'(n);
      end
      5'd28: begin
        while (n < 32 && a[n] == 1'b0) n++;
        r = 32'(n);
      end
      5'd29: r = 32'($countones(a));
      5'd30: r = (a << sh) | ((sh == 0) ? 32'h0 : (a >> (32 - sh)));
      5'd31: r = (a >> sh) | ((sh == 0) ? 32'h0 : (a << (32 - sh)));
    endcase
    return r;
  endfunction

  // Drive one cycle of inputs and queue the result expected after the next edge.
  task automatic drive_chk(input bit rn, input bit [4:0] op, input bit [31:0] a,
                           input bit [31:0] b, input bit [31:0] expv);
    @(negedge clk);
    rst_n        = rn;
    bus.alu_op   = op;
    bus.alu_src0 = a;
    bus.alu_src1 = b;
    sbq.push_back('{exp: expv, op: op, id: n_iss});
    n_iss++;
  endtask

  task automatic drive(input bit rn, input bit [4:0] op, input bit [31:0] a,
                       input bit [31:0] b);
    drive_chk(rn, op, a, b, rn ? model(op, a, b) : 32'h0);
  endtask

  // Inputs wiggle after the edge, settle before the next; only the settled values count.
  task automatic drive_glitch(input bit [4:0] op, input bit [31:0] a, input bit [31:0] b);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.alu_op   = 5'($urandom);
    bus.alu_src0 = $urandom;
    bus.alu_src1 = $urandom;
    #2;
    bus.alu_op   = op;
    bus.alu_src0 = a;
    bus.alu_src1 = b;
    sbq.push_back('{exp: model(op, a, b), op: op, id: n_iss});
    n_iss++;
  endtask

  function automatic bit [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'(32'h1 << $urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every cycle with an outstanding expectation, compare the output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_cmp++;
        if (bus.alu_res !== e.exp) begin
          n_bad++;
          $display("FAIL alu_res id=%0d op=%0d actual=%h required=%h",
                   e.id, e.op, bus.alu_res, e.exp);
        end
      end
    end
  end

  initial begin
    bit [31:0] sw[32];
    bit [4:0]  op;
    bit [31:0] ra;

    rst_n        = 1'b0;
    bus.alu_op   = '0;
    bus.alu_src0 = '0;
    bus.alu_src1 = '0;

    // Reset for two cycles with arbitrary inputs.
    repeat (2) drive(1'b0, 5'($urandom), $urandom, $urandom);

    // Opcode sweep a=FFFFFFFF b=2 with known constants, then wrap to op 0.
    for (int i = 0; i < 32; i++) sw[i] = model(5'(i), 32'hFFFF_FFFF, 32'h2);
    sw[0]  = 32'h0000_0001; sw[1]  = 32'hFFFF_FFFD; sw[2]  = 32'hFFFF_FFFC;
    sw[3]  = 32'h0000_0001; sw[4]  = 32'h0000_0000; sw[5]  = 32'hFFFF_FFFD;
    sw[6]  = 32'h3FFF_FFFF; sw[7]  = 32'hFFFF_FFFF; sw[12] = 32'hFFFF_FFFE;
    sw[13] = 32'hFFFF_FFFF; sw[14] = 32'hFFFF_FFFF; sw[15] = 32'h0000_0001;
    sw[20] = 32'hFFFF_FFFF; sw[23] = 32'hFFFF_FFFF; sw[27] = 32'h0000_0000;
    sw[28] = 32'h0000_0000; sw[29] = 32'h0000_0020; sw[31] = 32'hFFFF_FFFF;
    op = 5'd0;
    repeat (33) begin
      drive_chk(1'b1, op, 32'hFFFF_FFFF, 32'h2, sw[op]);
      op = op + 5'd1;
    end

    // Boundaries.
    drive_chk(1'b1, 5'd1,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF);
    drive_chk(1'b1, 5'd3,  32'h8000_0000, 32'h1, 32'h0000_0001);
    drive_chk(1'b1, 5'd4,  32'h8000_0000, 32'h1, 32'h0000_0000);
    drive_chk(1'b1, 5'd7,  32'h8000_0000, 32'h1, 32'hC000_0000);
    drive_chk(1'b1, 5'd27, 32'h0,         $urandom, 32'h0000_0020);
    drive_chk(1'b1, 5'd28, 32'h0,         $urandom, 32'h0000_0020);
    drive_chk(1'b1, 5'd29, 32'h0,         $urandom, 32'h0000_0000);
    drive_chk(1'b1, 5'd29, 32'hFFFF_FFFF, $urandom, 32'h0000_0020);
    ra = $urandom;
    drive_chk(1'b1, 5'd2,  ra, 32'hFFFF_FFE0, ra);
    drive_chk(1'b1, 5'd30, ra, 32'hFFFF_FFE0, ra);
    drive_chk(1'b1, 5'd31, ra, 32'hFFFF_FFE0, ra);
    drive_chk(1'b1, 5'd7,  ra, 32'hFFFF_FFE0, ra);
    drive_chk(1'b1, 5'd30, 32'h8000_0001, 32'h21, 32'h0000_0003);
    drive_chk(1'b1, 5'd31, 32'h8000_0001, 32'h21, 32'hC000_0000);

    // Reset mid-stream overrides the pending result; first cycle after release computes.
    drive(1'b1, 5'd0, 32'h1234_5678, 32'h1111_1111);
    drive(1'b0, 5'd11, 32'hDEAD_BEEF, 32'h0);
    drive(1'b0, 5'd11, 32'hDEAD_BEEF, 32'h0);
    drive_chk(1'b1, 5'd11, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);

    // Inputs changing mid-cycle.
    repeat (20) drive_glitch(5'($urandom), pick(), pick());

    // Random back-to-back traffic with occasional resets.
    repeat (400) begin
      if ($urandom_range(0, 49) == 0) drive(1'b0, 5'($urandom), $urandom, $urandom);
      else                            drive(1'b1, 5'($urandom), pick(), pick());
    end

    // Drain with a bound.
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain outstanding=%0d required=0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
